// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Function : Multi-cycle fetch/decode/read/execute/write control FSM for the
//            16-bit-instruction datapath.
// Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int PC_W  = 4,
    parameter int IW    = 16,
    parameter int RA_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt_req,
    output logic [PC_W-1:0]  imem_addr,
    output logic             imem_rd,
    input  logic [IW-1:0]    imem_rdata,
    input  logic             imem_valid,
    output logic [RA_W-1:0]  rf_raddr1,
    output logic [RA_W-1:0]  rf_raddr2,
    output logic             rf_rd,
    output logic [RA_W-1:0]  rf_waddr,
    output logic             rf_we,
    output logic [3:0]       alu_op,
    output logic             alu_start,
    input  logic             alu_done,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] c_OP_NOP  = 4'h0;
    localparam logic [3:0] c_OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_READ   = 3'd3,
        S_EXEC   = 3'd4,
        S_WRITE  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [IW-1:0]   r_ir;
    logic [3:0]      r_op;
    logic [3:0]      r_rdst;
    logic            r_halt_pend;

    // Outputs are registered alongside the state transition so each control
    // line is high exactly while the FSM sits in its owning state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_ir        <= '0;
            r_op        <= '0;
            r_rdst      <= '0;
            r_halt_pend <= 1'b0;
            imem_addr   <= '0;
            imem_rd     <= 1'b0;
            rf_raddr1   <= '0;
            rf_raddr2   <= '0;
            rf_rd       <= 1'b0;
            rf_waddr    <= '0;
            rf_we       <= 1'b0;
            alu_op      <= '0;
            alu_start   <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            retired     <= '0;
        end else begin
            if (halt_req && (r_state != S_IDLE) && (r_state != S_HALT))
                r_halt_pend <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_FETCH;
                        imem_rd   <= 1'b1;
                        imem_addr <= r_pc;
                        busy      <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        r_ir    <= imem_rdata;
                        r_pc    <= r_pc + PC_W'(1);
                        imem_rd <= 1'b0;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_op   <= r_ir[15:12];
                    r_rdst <= r_ir[3:0];
                    if (r_ir[15:12] == c_OP_HALT) begin
                        r_state     <= S_HALT;
                        halted      <= 1'b1;
                        // Stopping here already honours any pending halt request.
                        r_halt_pend <= 1'b0;
                    end else begin
                        r_state   <= S_READ;
                        rf_rd     <= 1'b1;
                        rf_raddr1 <= RA_W'(r_ir[7:4]);
                        rf_raddr2 <= RA_W'(r_ir[11:8]);
                    end
                end
                S_READ: begin
                    rf_rd     <= 1'b0;
                    alu_start <= 1'b1;
                    alu_op    <= r_op;
                    r_state   <= S_EXEC;
                end
                S_EXEC: begin
                    if (alu_done) begin
                        alu_start <= 1'b0;
                        rf_we     <= (r_op != c_OP_NOP);
                        rf_waddr  <= RA_W'(r_rdst);
                        r_state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    rf_we       <= 1'b0;
                    r_halt_pend <= 1'b0;
                    if (retired != {CNT_W{1'b1}})
                        retired <= retired + CNT_W'(1);
                    if (r_halt_pend || halt_req) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_state   <= S_FETCH;
                        imem_rd   <= 1'b1;
                        imem_addr <= r_pc;
                    end
                end
                S_HALT: begin
                    if (start) begin
                        halted    <= 1'b0;
                        r_state   <= S_FETCH;
                        imem_rd   <= 1'b1;
                        imem_addr <= r_pc;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    imem_rd   <= 1'b0;
                    rf_rd     <= 1'b0;
                    rf_we     <= 1'b0;
                    alu_start <= 1'b0;
                    busy      <= 1'b0;
                    halted    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Function : Directed/randomized self-checking bench for instr_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    localparam int PC_W  = 4;
    localparam int IW    = 16;
    localparam int RA_W  = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             halt_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_rd;
    logic [IW-1:0]    imem_rdata;
    logic             imem_valid;
    logic [RA_W-1:0]  rf_raddr1;
    logic [RA_W-1:0]  rf_raddr2;
    logic             rf_rd;
    logic [RA_W-1:0]  rf_waddr;
    logic             rf_we;
    logic [3:0]       alu_op;
    logic             alu_start;
    logic             alu_done;
    logic             busy;
    logic             halted;
    logic [CNT_W-1:0] retired;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: architectural pc, retired count, pending halt.
    int          exp_pc;
    int          exp_retired;
    bit          exp_halt_pend;
    logic [15:0] prog [16];

    instr_sequencer #(
        .PC_W (PC_W),
        .IW   (IW),
        .RA_W (RA_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .halt_req  (halt_req),
        .imem_addr (imem_addr),
        .imem_rd   (imem_rd),
        .imem_rdata(imem_rdata),
        .imem_valid(imem_valid),
        .rf_raddr1 (rf_raddr1),
        .rf_raddr2 (rf_raddr2),
        .rf_rd     (rf_rd),
        .rf_waddr  (rf_waddr),
        .rf_we     (rf_we),
        .alu_op    (alu_op),
        .alu_start (alu_start),
        .alu_done  (alu_done),
        .busy      (busy),
        .halted    (halted),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check("exclusive_ctrl", 32'($countones({rf_rd, rf_we, alu_start, imem_rd}) <= 1), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_imem_rd"},   imem_rd, 0);
        check({tag, "_rf_rd"},     rf_rd, 0);
        check({tag, "_rf_we"},     rf_we, 0);
        check({tag, "_alu_start"}, alu_start, 0);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_halted"},    halted, 0);
        check({tag, "_imem_addr"}, imem_addr, 0);
        check({tag, "_raddr1"},    rf_raddr1, 0);
        check({tag, "_raddr2"},    rf_raddr2, 0);
        check({tag, "_waddr"},     rf_waddr, 0);
        check({tag, "_alu_op"},    alu_op, 0);
        check({tag, "_retired"},   retired, 0);
    endtask

    task automatic begin_run();
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_fetch_rd",   imem_rd, 1);
        check("start_fetch_addr", imem_addr, exp_pc);
        check("start_busy",       busy, 1);
        check("start_halted",     halted, 0);
    endtask

    // Runs one instruction starting from the first FETCH cycle; the model
    // expects FETCH for iw+1 cycles, then DECODE, READ, EXEC for aw+1, WRITE.
    task automatic do_instr(input logic [15:0] instr, input int iw, input int aw,
                            input bit hreq, input bit abort);
        logic [3:0] op;
        op = instr[15:12];
        for (int k = 0; k <= iw; k++) begin
            imem_valid = (k == iw);
            imem_rdata = (k == iw) ? instr : 16'($urandom);
            step();
            if (k < iw) begin
                check("fetch_hold_rd",   imem_rd, 1);
                check("fetch_hold_addr", imem_addr, exp_pc);
            end
        end
        imem_valid = 1'b0;
        check("decode_imem_rd", imem_rd, 0);
        check("decode_rf_rd",   rf_rd, 0);
        exp_pc = (exp_pc + 1) % 16;
        step();
        if (op == 4'hF) begin
            check("halt_halted",  halted, 1);
            check("halt_busy",    busy, 1);
            check("halt_retired", retired, exp_retired);
            check("halt_imem_rd", imem_rd, 0);
            exp_halt_pend = 1'b0;
            return;
        end
        check("read_rf_rd",  rf_rd, 1);
        check("read_raddr1", rf_raddr1, instr[7:4]);
        check("read_raddr2", rf_raddr2, instr[11:8]);
        check("read_alu",    alu_start, 0);
        step();
        check("exec_rf_rd",  rf_rd, 0);
        check("exec_start",  alu_start, 1);
        check("exec_alu_op", alu_op, op);
        if (abort) begin
            #2 rst_n = 1'b0;
            #1;
            check_all_zero("abort");
            exp_pc        = 0;
            exp_retired   = 0;
            exp_halt_pend = 1'b0;
            return;
        end
        for (int j = 0; j <= aw; j++) begin
            alu_done = (j == aw);
            halt_req = hreq && (j == 0);
            if (halt_req) exp_halt_pend = 1'b1;
            step();
            if (j < aw) begin
                check("exec_hold_start", alu_start, 1);
                check("exec_hold_op",    alu_op, op);
                check("exec_hold_we",    rf_we, 0);
            end
        end
        alu_done = 1'b0;
        halt_req = 1'b0;
        check("write_we",    rf_we, (op != 4'h0));
        if (op != 4'h0) check("write_waddr", rf_waddr, instr[3:0]);
        check("write_start", alu_start, 0);
        if (exp_retired < 65535) exp_retired++;
        step();
        check("post_write_we", rf_we, 0);
        check("retired",       retired, exp_retired);
        if (exp_halt_pend) begin
            check("stop_busy",    busy, 0);
            check("stop_imem_rd", imem_rd, 0);
            exp_halt_pend = 1'b0;
        end else begin
            check("next_fetch_rd",   imem_rd, 1);
            check("next_fetch_addr", imem_addr, exp_pc);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        halt_req   = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = '0;
        alu_done   = 1'b0;
        for (int i = 0; i < 16; i++)
            prog[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        prog[0]       = 16'h3214;
        exp_pc        = 0;
        exp_retired   = 0;
        exp_halt_pend = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        step();
        check("idle_busy",    busy, 0);
        check("idle_imem_rd", imem_rd, 0);

        // halt_req alongside start in IDLE must not stop the first instruction.
        halt_req = 1'b1;
        begin_run();
        halt_req = 1'b0;
        do_instr(prog[0], 0, 0, 1'b0, 1'b0);
        do_instr(prog[1], 3, 2, 1'b0, 1'b0);
        for (int i = 2; i < 16; i++)
            do_instr(prog[exp_pc], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 1'b0);
        check("retired_16", retired, 16);
        check("wrap_addr",  imem_addr, 0);

        do_instr(16'h0ABC, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0, 1'b0);
        do_instr(16'hF000, 0, 0, 1'b0, 1'b0);
        repeat (3) begin
            step();
            check("halted_stay", halted, 1);
            check("halted_busy", busy, 1);
            check("halted_rd",   imem_rd, 0);
        end
        check("halted_retired", retired, exp_retired);

        begin_run();
        do_instr(16'h1123, 1, 2, 1'b1, 1'b0);
        repeat (3) begin
            step();
            check("idle_after_halt_busy", busy, 0);
            check("idle_after_halt_rd",   imem_rd, 0);
        end

        begin_run();
        do_instr(prog[exp_pc], 1, 3, 1'b0, 1'b1);
        step();
        check_all_zero("in_reset");
        rst_n = 1'b1;
        step();
        check("post_reset_busy", busy, 0);
        begin_run();
        for (int i = 0; i < 4; i++)
            do_instr(prog[exp_pc], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control FSM for the 16-bit-instruction processor datapath.
- Sequences one instruction at a time: fetch from instruction memory, decode fields, read the register file, launch the ALU, write the result back.
- Replaces the free-running, delay-staggered stage flags with explicit states and explicit handshakes. The block drives only control and address signals; data moves directly between memory, register file and ALU.

Parameters:
- PC_W, 4: program counter / instruction address width.
- IW, 16: instruction width. Fields: op=[15:12], rsrc2=[11:8], rsrc1=[7:4], rdst=[3:0].
- RA_W, 4: register address width.
- CNT_W, 16: retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; leaves IDLE and begins fetching at the current pc.
- halt_req  in  1  pulse or level; stop after the current instruction retires.
- imem_addr  out  PC_W  instruction address, equal to pc.
- imem_rd  out  1  instruction read request.
- imem_rdata  in  IW  instruction word.
- imem_valid  in  1  imem_rdata valid this cycle.
- rf_raddr1  out  RA_W  source-1 register address.
- rf_raddr2  out  RA_W  source-2 register address.
- rf_rd  out  1  register read enable.
- rf_waddr  out  RA_W  destination register address.
- rf_we  out  1  register write enable.
- alu_op  out  4  ALU opcode.
- alu_start  out  1  ALU request.
- alu_done  in  1  ALU result valid.
- busy  out  1  high whenever state is not IDLE.
- halted  out  1  high in HALT.
- retired  out  CNT_W  count of instructions written back.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=0, ir=0, retired=0, halt_pend=0. All outputs 0: imem_rd, rf_rd, rf_we, alu_start, busy, halted, and all address/op outputs. Reset asserted mid-instruction aborts it immediately; rf_we falls asynchronously and no write occurs.
- States: IDLE, FETCH, DECODE, READ, EXEC, WRITE, HALT.
- IDLE: if start=1, go to FETCH next cycle.
- FETCH:
  - imem_rd=1, imem_addr=pc; hold both until imem_valid=1.
  - On the imem_valid cycle: ir<=imem_rdata, pc<=pc+1 (wraps 2^PC_W-1 -> 0), go to DECODE.
  - No timeout; the FSM waits indefinitely.
- DECODE:
  - Register op, rsrc1, rsrc2, rdst from ir.
  - op=4'hF (HALT) goes to HALT; retired is unchanged and pc already points past the HALT instruction.
  - Any other op goes to READ.
- READ:
  - rf_rd=1 for exactly one cycle, with rf_raddr1=rsrc1 and rf_raddr2=rsrc2.
  - Operands are valid at the ALU inputs by the next cycle; go to EXEC.
- EXEC:
  - alu_start=1 and alu_op=op, both held until alu_done=1.
  - alu_done in the first EXEC cycle is legal; go to WRITE the cycle after alu_done.
- WRITE:
  - rf_we=1 for exactly one cycle with rf_waddr=rdst, except op=4'h0 (NOP), where rf_we stays 0.
  - retired<=retired+1, saturating at all-ones. NOPs count as retired.
  - Next state is IDLE if halt_pend=1 or halt_req=1 (then clear halt_pend), else FETCH.
- halt_req:
  - Any cycle it is high outside IDLE/HALT sets halt_pend.
  - In IDLE, halt_req has no effect and start takes priority.
- HALT: halted=1; stays until reset, or start=1, which clears halted and goes to FETCH at the current pc.
- Output rules:
  - Control outputs are Moore, decoded from registered state.
  - imem_addr, rf_raddr*, rf_waddr and alu_op hold their last values outside their active states.
- Baseline timing with zero-wait memory and ALU: 5 cycles per instruction (FETCH, DECODE, READ, EXEC, WRITE). Each extra wait cycle on imem_valid or alu_done adds exactly one cycle.
- Invariant: rf_rd, rf_we, alu_start and imem_rd are mutually exclusive (never two high in the same cycle).

Test Plan:
- Reset, start=1, imem returns 16'h3214 with zero wait, alu_done tied high:
  - rf_raddr1=1, rf_raddr2=2, alu_op=3.
  - rf_we pulses with rf_waddr=4 at cycle 5 after leaving IDLE.
  - pc=1, retired=1.
- imem_valid delayed 3 cycles, alu_done delayed 2 cycles:
  - imem_rd held 4 cycles, alu_start held 3 cycles.
  - Instruction completes in 10 cycles; address and op outputs are stable throughout each wait.
- 16 sequential non-HALT instructions starting from pc=0:
  - pc wraps 15 -> 0 and the 17th fetch uses addr 0.
  - retired=16.
- Instruction 16'h0ABC (NOP): no rf_we pulse, retired increments, next FETCH follows immediately. Then 16'hF000: halted=1, busy stays 1, retired unchanged, imem_rd stays 0.
- Pulse halt_req during EXEC of 16'h1123: the write to r3 still occurs, the next state is IDLE, busy=0, and no further imem_rd.
- Drop rst_n during EXEC wait:
  - All outputs 0 immediately, retired=0, pc=0.
  - After rst_n rises and start=1, the first fetch uses addr 0.
